// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit reorder buffer with writeback, operand lookup and mispredict flush
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_AW    = 4,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              alloc_valid,
  input  logic [4:0]        alloc_dest_reg,
  input  logic              alloc_is_branch,
  output logic [ROB_AW-1:0] alloc_rob_num,
  output logic              rob_full,
  input  logic              wb_valid,
  input  logic [ROB_AW-1:0] wb_rob_num,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_mispredict,
  input  logic [DATA_W-1:0] wb_target_pc,
  input  logic [ROB_AW-1:0] q1_rob_num,
  input  logic [ROB_AW-1:0] q2_rob_num,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data,
  output logic              has_from_rob,
  output logic [4:0]        dest_reg_num,
  output logic [DATA_W-1:0] in_reg_data,
  output logic [ROB_AW-1:0] in_reg_rob_num,
  output logic              has_misbranch,
  output logic [DATA_W-1:0] misbranch_pc
);

  localparam logic [ROB_AW:0] FULL_CNT = (ROB_AW + 1)'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0] busy_q, busy_d, ready_q, ready_d;
  logic [ROB_DEPTH-1:0] is_branch_q, is_branch_d, mispredict_q, mispredict_d;
  logic [4:0]           dest_q [ROB_DEPTH];
  logic [4:0]           dest_d [ROB_DEPTH];
  logic [DATA_W-1:0]    data_q [ROB_DEPTH];
  logic [DATA_W-1:0]    data_d [ROB_DEPTH];
  logic [DATA_W-1:0]    target_q [ROB_DEPTH];
  logic [DATA_W-1:0]    target_d [ROB_DEPTH];
  logic [ROB_AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [ROB_AW:0]      count_q, count_d;
  logic                 has_misbranch_q, has_misbranch_d;
  logic [DATA_W-1:0]    misbranch_pc_q, misbranch_pc_d;
  logic                 do_alloc, q1_bypass, q2_bypass;

  assign rob_full       = (count_q == FULL_CNT);
  assign alloc_rob_num  = tail_q;
  assign do_alloc       = rdy && alloc_valid && !rob_full && !has_misbranch_q;
  assign has_from_rob   = rdy && !has_misbranch_q && busy_q[head_q] && ready_q[head_q];
  assign dest_reg_num   = dest_q[head_q];
  assign in_reg_data    = data_q[head_q];
  assign in_reg_rob_num = head_q;
  assign has_misbranch  = has_misbranch_q;
  assign misbranch_pc   = misbranch_pc_q;

  // Operand lookup: a result being broadcast this cycle is forwarded ahead of stored data
  assign q1_bypass = wb_valid && (wb_rob_num == q1_rob_num);
  assign q2_bypass = wb_valid && (wb_rob_num == q2_rob_num);
  assign q1_ready  = (busy_q[q1_rob_num] && ready_q[q1_rob_num]) || q1_bypass;
  assign q2_ready  = (busy_q[q2_rob_num] && ready_q[q2_rob_num]) || q2_bypass;
  assign q1_data   = q1_bypass ? wb_data : data_q[q1_rob_num];
  assign q2_data   = q2_bypass ? wb_data : data_q[q2_rob_num];

  // Next state: flush on a pending misbranch, else writeback, commit and allocate
  always_comb begin
    busy_d          = busy_q;
    ready_d         = ready_q;
    is_branch_d     = is_branch_q;
    mispredict_d    = mispredict_q;
    dest_d          = dest_q;
    data_d          = data_q;
    target_d        = target_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    has_misbranch_d = has_misbranch_q;
    misbranch_pc_d  = misbranch_pc_q;
    if (rdy) begin
      if (has_misbranch_q) begin
        busy_d          = '0;
        head_d          = '0;
        tail_d          = '0;
        count_d         = '0;
        has_misbranch_d = 1'b0;
      end else begin
        if (wb_valid && busy_q[wb_rob_num]) begin
          ready_d[wb_rob_num]      = 1'b1;
          data_d[wb_rob_num]       = wb_data;
          mispredict_d[wb_rob_num] = wb_mispredict;
          target_d[wb_rob_num]     = wb_target_pc;
        end
        // Commit decisions use the head's stored fields, not this cycle's writeback
        if (has_from_rob) begin
          busy_d[head_q] = 1'b0;
          head_d         = head_q + 1'b1;
          if (is_branch_q[head_q] && mispredict_q[head_q]) begin
            has_misbranch_d = 1'b1;
            misbranch_pc_d  = target_q[head_q];
          end
        end
        if (do_alloc) begin
          busy_d[tail_q]       = 1'b1;
          ready_d[tail_q]      = 1'b0;
          mispredict_d[tail_q] = 1'b0;
          is_branch_d[tail_q]  = alloc_is_branch;
          dest_d[tail_q]       = alloc_dest_reg;
          tail_d               = tail_q + 1'b1;
        end
        case ({do_alloc, has_from_rob})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end
    end
  end

  // State register; reset also clears payload so commit outputs read zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q          <= '0;
      ready_q         <= '0;
      is_branch_q     <= '0;
      mispredict_q    <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      has_misbranch_q <= 1'b0;
      misbranch_pc_q  <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        dest_q[i]   <= '0;
        data_q[i]   <= '0;
        target_q[i] <= '0;
      end
    end else begin
      busy_q          <= busy_d;
      ready_q         <= ready_d;
      is_branch_q     <= is_branch_d;
      mispredict_q    <= mispredict_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      has_misbranch_q <= has_misbranch_d;
      misbranch_pc_q  <= misbranch_pc_d;
      dest_q          <= dest_d;
      data_q          <= data_d;
      target_q        <= target_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed and random checks of reorder_buffer against a program-order queue model
module tb_reorder_buffer;
  localparam int D = 16;

  logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1;
  logic        alloc_valid = 1'b0, alloc_is_branch = 1'b0;
  logic [4:0]  alloc_dest_reg = '0;
  logic [3:0]  alloc_rob_num;
  logic        rob_full;
  logic        wb_valid = 1'b0, wb_mispredict = 1'b0;
  logic [3:0]  wb_rob_num = '0;
  logic [31:0] wb_data = '0, wb_target_pc = '0;
  logic [3:0]  q1_rob_num = '0, q2_rob_num = '0;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_data, q2_data;
  logic        has_from_rob, has_misbranch;
  logic [4:0]  dest_reg_num;
  logic [31:0] in_reg_data, misbranch_pc;
  logic [3:0]  in_reg_rob_num;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  rob;
    logic [4:0]  dest;
    logic [31:0] data;
    bit          done;
    bit          br;
    bit          mp;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  int          m_tail = 0;
  bit          m_mis = 0;
  logic [31:0] m_pc = '0;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_DEPTH(16), .ROB_AW(4), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_dest_reg(alloc_dest_reg), .alloc_is_branch(alloc_is_branch),
    .alloc_rob_num(alloc_rob_num), .rob_full(rob_full),
    .wb_valid(wb_valid), .wb_rob_num(wb_rob_num), .wb_data(wb_data),
    .wb_mispredict(wb_mispredict), .wb_target_pc(wb_target_pc),
    .q1_rob_num(q1_rob_num), .q2_rob_num(q2_rob_num), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data),
    .has_from_rob(has_from_rob), .dest_reg_num(dest_reg_num), .in_reg_data(in_reg_data),
    .in_reg_rob_num(in_reg_rob_num), .has_misbranch(has_misbranch), .misbranch_pc(misbranch_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int find(input logic [3:0] r);
    foreach (mq[i]) if (mq[i].rob == r) return i;
    return -1;
  endfunction

  task automatic idle();
    rdy = 1'b1; alloc_valid = 1'b0; alloc_is_branch = 1'b0; alloc_dest_reg = '0;
    wb_valid = 1'b0; wb_mispredict = 1'b0; wb_rob_num = '0; wb_data = '0; wb_target_pc = '0;
  endtask

  task automatic check_q(input string tag, input logic [3:0] qn, input logic qr, input logic [31:0] qd);
    int k;
    k = find(qn);
    if (wb_valid && wb_rob_num == qn) begin
      chk({tag, "_ready_bypass"}, qr, 1);
      chk({tag, "_data_bypass"}, qd, wb_data);
    end else if (k >= 0 && mq[k].done) begin
      chk({tag, "_ready"}, qr, 1);
      chk({tag, "_data"}, qd, mq[k].data);
    end else begin
      chk({tag, "_not_ready"}, qr, 0);
    end
  endtask

  task automatic check_outputs();
    bit ec;
    chk("rob_full", rob_full, 32'(mq.size() == D));
    chk("alloc_rob_num", alloc_rob_num, 32'(m_tail));
    ec = rdy && !m_mis && mq.size() > 0 && mq[0].done;
    chk("has_from_rob", has_from_rob, 32'(ec));
    if (ec) begin
      chk("dest_reg_num", dest_reg_num, mq[0].dest);
      chk("in_reg_data", in_reg_data, mq[0].data);
      chk("in_reg_rob_num", in_reg_rob_num, mq[0].rob);
    end
    chk("has_misbranch", has_misbranch, 32'(m_mis));
    if (m_mis) chk("misbranch_pc", misbranch_pc, m_pc);
    check_q("q1", q1_rob_num, q1_ready, q1_data);
    check_q("q2", q2_rob_num, q2_ready, q2_data);
  endtask

  task automatic model_update();
    bit   commit;
    ent_t h;
    int   k;
    if (!rdy) return;
    if (m_mis) begin
      mq.delete(); m_tail = 0; m_mis = 0;
      return;
    end
    commit = mq.size() > 0 && mq[0].done;
    if (commit) h = mq[0];
    if (wb_valid) begin
      k = find(wb_rob_num);
      if (k >= 0) begin
        mq[k].done = 1; mq[k].data = wb_data; mq[k].mp = wb_mispredict; mq[k].tgt = wb_target_pc;
      end
    end
    if (alloc_valid && mq.size() < D) begin
      mq.push_back('{rob: 4'(m_tail), dest: alloc_dest_reg, data: '0, done: 0,
                     br: alloc_is_branch, mp: 0, tgt: '0});
      m_tail = (m_tail + 1) % D;
    end
    if (commit) begin
      void'(mq.pop_front());
      if (h.br && h.mp) begin m_mis = 1; m_pc = h.tgt; end
    end
  endtask

  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_rob_full", rob_full, 0);
    chk("rst_alloc_rob_num", alloc_rob_num, 0);
    chk("rst_has_from_rob", has_from_rob, 0);
    chk("rst_dest_reg_num", dest_reg_num, 0);
    chk("rst_in_reg_data", in_reg_data, 0);
    chk("rst_in_reg_rob_num", in_reg_rob_num, 0);
    chk("rst_has_misbranch", has_misbranch, 0);
    chk("rst_misbranch_pc", misbranch_pc, 0);
    mq.delete(); m_tail = 0; m_mis = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic alloc(input logic [4:0] d, input logic br);
    idle(); alloc_valid = 1'b1; alloc_dest_reg = d; alloc_is_branch = br;
    step();
  endtask

  task automatic wb(input logic [3:0] r, input logic [31:0] dat, input logic mp, input logic [31:0] tgt);
    idle(); wb_valid = 1'b1; wb_rob_num = r; wb_data = dat; wb_mispredict = mp; wb_target_pc = tgt;
    step();
  endtask

  initial begin
    // Single instruction round trip
    do_reset();
    alloc(5'd5, 0);
    wb(4'd0, 32'h1234, 0, 0);
    idle(); #1;
    chk("t028_commit", has_from_rob, 1);
    chk("t028_dest", dest_reg_num, 5);
    chk("t028_data", in_reg_data, 32'h1234);
    step();
    step();

    // Fill, reject overflow, retire one, wrap tail
    do_reset();
    for (int i = 0; i < 16; i++) alloc(5'(i + 1), 0);
    #1; chk("t029_full", rob_full, 1);
    alloc(5'd20, 0);
    wb(4'd0, 32'h55, 0, 0);
    idle(); step();
    #1; chk("t029_not_full", rob_full, 0);
    alloc(5'd21, 0);
    idle(); step();

    // Out-of-order writeback, in-order commit
    do_reset();
    for (int i = 0; i < 3; i++) alloc(5'(i + 1), 0);
    wb(4'd2, 32'hC2, 0, 0);
    wb(4'd1, 32'hC1, 0, 0);
    wb(4'd0, 32'hC0, 0, 0);
    for (int i = 0; i < 4; i++) begin idle(); step(); end

    // Mispredicted branch flushes younger entries
    do_reset();
    alloc(5'd1, 0); alloc(5'd2, 1); alloc(5'd3, 0); alloc(5'd4, 0);
    wb(4'd0, 32'hA0, 0, 0);
    wb(4'd1, 32'hA1, 1, 32'h80);
    wb(4'd2, 32'hA2, 0, 0);
    idle(); #1;
    chk("t031_misbranch", has_misbranch, 1);
    chk("t031_pc", misbranch_pc, 32'h80);
    step();
    for (int i = 0; i < 3; i++) begin idle(); step(); end

    // Bypass lookup and rdy stall
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 8), 0);
    idle(); q1_rob_num = 4'd3; wb_valid = 1'b1; wb_rob_num = 4'd3; wb_data = 32'hABCD;
    #1;
    chk("t032_q1_ready", q1_ready, 1);
    chk("t032_q1_data", q1_data, 32'hABCD);
    step();
    wb(4'd0, 32'h77, 0, 0);
    for (int i = 0; i < 3; i++) begin idle(); rdy = 1'b0; step(); end
    idle(); step();
    idle(); step();

    // Random traffic with phases that fill and drain, plus a mid-run reset
    for (int i = 0; i < 600; i++) begin
      bit fill;
      if (i == 300) do_reset();
      fill = ((i / 40) % 2) == 0;
      idle();
      rdy             = ($urandom_range(0, 9) != 0);
      alloc_valid     = fill ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      alloc_dest_reg  = 5'($urandom);
      alloc_is_branch = ($urandom_range(0, 3) == 0);
      wb_valid        = fill ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        wb_rob_num = mq[$urandom_range(0, mq.size() - 1)].rob;
      else
        wb_rob_num = 4'($urandom);
      wb_data       = $urandom;
      wb_mispredict = ($urandom_range(0, 4) == 0);
      wb_target_pc  = $urandom;
      q1_rob_num    = ($urandom_range(0, 3) == 0) ? wb_rob_num : 4'($urandom);
      q2_rob_num    = 4'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
